// File: rtl/qacc_frame.sv
// Frame accumulator for signed Q-format products: sums one frame of terms into a
// guarded accumulator and hands back a saturated N-bit result with sticky overflow.
module qacc_frame #(
    parameter int Q  = 8,
    parameter int N  = 16,
    parameter int G  = 4,
    parameter int CW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [N-1:0]  i_prod,
    input  logic          i_prod_ovr,
    input  logic          i_valid,
    input  logic          i_last,
    output logic          o_ready,
    output logic [N-1:0]  o_sum,
    output logic          o_ovr,
    output logic [CW-1:0] o_count,
    output logic          o_valid,
    input  logic          i_out_ready
);

    localparam int AW = N + G;

    if (Q >= N) begin : g_bad_q
        $error("qacc_frame: Q must be smaller than N");
    end

    typedef enum logic [1:0] {IDLE, ACC, DONE, HOLD} state_t;

    state_t        state;
    logic [AW-1:0] acc;
    logic [CW-1:0] count;
    logic          sticky;

    logic          accept;
    logic [AW-1:0] prod_ext;
    logic [AW:0]   sum_wide;
    logic [AW-1:0] sum_clamped;
    logic          add_clamp;
    logic          cnt_full;
    logic          acc_in_range;
    logic [N-1:0]  acc_sat;

    assign o_ready  = (state == IDLE) || (state == ACC);
    assign accept   = i_valid && o_ready;
    assign prod_ext = {{G{i_prod[N-1]}}, i_prod};
    assign sum_wide = {acc[AW-1], acc} + {prod_ext[AW-1], prod_ext};
    assign cnt_full = (count == {CW{1'b1}});

    // The extra sum bit disagreeing with the accumulator sign bit means the add left the guarded range.
    always_comb begin
        add_clamp   = (sum_wide[AW] != sum_wide[AW-1]);
        sum_clamped = sum_wide[AW-1:0];
        if (add_clamp) begin
            sum_clamped = sum_wide[AW] ? {1'b1, {(AW-1){1'b0}}} : {1'b0, {(AW-1){1'b1}}};
        end
    end

    // The accumulator fits N bits only when all bits from N-1 upward are copies of the sign.
    always_comb begin
        acc_in_range = (acc[AW-1:N-1] == '0) || (acc[AW-1:N-1] == '1);
        acc_sat      = acc[N-1:0];
        if (!acc_in_range) begin
            acc_sat = acc[AW-1] ? {1'b1, {(N-1){1'b0}}} : {1'b0, {(N-1){1'b1}}};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            acc     <= '0;
            count   <= '0;
            sticky  <= 1'b0;
            o_sum   <= '0;
            o_ovr   <= 1'b0;
            o_count <= '0;
            o_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        acc    <= prod_ext;
                        count  <= {{(CW-1){1'b0}}, 1'b1};
                        sticky <= i_prod_ovr;
                        state  <= i_last ? DONE : ACC;
                    end
                end
                ACC: begin
                    if (accept) begin
                        acc    <= sum_clamped;
                        count  <= cnt_full ? count : count + 1'b1;
                        sticky <= sticky | i_prod_ovr | add_clamp | cnt_full;
                        if (i_last) begin
                            state <= DONE;
                        end
                    end
                end
                DONE: begin
                    o_sum   <= acc_sat;
                    o_ovr   <= sticky | ~acc_in_range;
                    o_count <= count;
                    o_valid <= 1'b1;
                    state   <= HOLD;
                end
                HOLD: begin
                    if (i_out_ready) begin
                        o_valid <= 1'b0;
                        acc     <= '0;
                        count   <= '0;
                        sticky  <= 1'b0;
                        state   <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_qacc_frame.sv
// Self-checking bench for qacc_frame: a reference model pushes expected frame
// results into a queue, and a monitor pops and compares them on each output handshake.
module tb_qacc_frame;

    localparam int N  = 16;
    localparam int G  = 4;
    localparam int CW = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic [N-1:0]  i_prod;
    logic          i_prod_ovr;
    logic          i_valid;
    logic          i_last;
    logic          o_ready;
    logic [N-1:0]  o_sum;
    logic          o_ovr;
    logic [CW-1:0] o_count;
    logic          o_valid;
    logic          i_out_ready;

    typedef struct {
        logic [N-1:0]  sum;
        logic          ovr;
        logic [CW-1:0] count;
    } result_t;

    result_t expQueue[$];
    int numCompared   = 0;
    int numMismatched = 0;

    // Reference model state
    int  modelAcc;
    int  modelCount;
    bit  modelSticky;
    bit  modelFirst = 1'b1;

    qacc_frame #(.Q(8), .N(N), .G(G), .CW(CW)) dut (
        .clk(clk), .rst(rst),
        .i_prod(i_prod), .i_prod_ovr(i_prod_ovr), .i_valid(i_valid), .i_last(i_last),
        .o_ready(o_ready), .o_sum(o_sum), .o_ovr(o_ovr), .o_count(o_count),
        .o_valid(o_valid), .i_out_ready(i_out_ready)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        numCompared++;
        if (actual !== expected) begin
            numMismatched++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    function automatic void modelAccept(input logic [N-1:0] p, input logic ovr, input logic last);
        int term;
        int accMax;
        int accMin;
        int nMax;
        int nMin;
        result_t r;
        term   = int'(signed'(p));
        accMax = (1 << (N + G - 1)) - 1;
        accMin = -(1 << (N + G - 1));
        nMax   = (1 << (N - 1)) - 1;
        nMin   = -(1 << (N - 1));
        if (modelFirst) begin
            modelAcc    = term;
            modelCount  = 1;
            modelSticky = ovr;
            modelFirst  = 1'b0;
        end else begin
            modelAcc = modelAcc + term;
            if (modelAcc > accMax) begin modelAcc = accMax; modelSticky = 1'b1; end
            if (modelAcc < accMin) begin modelAcc = accMin; modelSticky = 1'b1; end
            if (modelCount == (1 << CW) - 1) modelSticky = 1'b1;
            else modelCount++;
            if (ovr) modelSticky = 1'b1;
        end
        if (last) begin
            r.ovr = modelSticky || modelAcc > nMax || modelAcc < nMin;
            if (modelAcc > nMax)      r.sum = N'(nMax);
            else if (modelAcc < nMin) r.sum = N'(nMin);
            else                      r.sum = N'(modelAcc);
            r.count = CW'(modelCount);
            expQueue.push_back(r);
            modelFirst = 1'b1;
        end
    endfunction

    // Drive one term and wait (bounded) until the DUT accepts it; returns 1 ns after the accepting edge.
    task automatic applyStimulus(input logic [N-1:0] p, input logic ovr, input logic last);
        int waitCycles = 0;
        @(negedge clk);
        i_prod     = p;
        i_prod_ovr = ovr;
        i_last     = last;
        i_valid    = 1'b1;
        while (!o_ready && waitCycles < 50) begin
            @(negedge clk);
            waitCycles++;
        end
        if (!o_ready) begin
            checkOutput("accept_timeout", 32'(o_ready), 32'd1);
        end else begin
            modelAccept(p, ovr, last);
        end
        @(posedge clk);
        #1;
        i_valid = 1'b0;
        i_last  = 1'b0;
    endtask

    // Scoreboard monitor: compare whenever a result is handed downstream.
    always @(negedge clk) begin
        if (!rst && o_valid && i_out_ready) begin
            if (expQueue.size() == 0) begin
                checkOutput("unexpected_result", 32'(o_valid), 32'd0);
            end else begin
                result_t e;
                e = expQueue.pop_front();
                checkOutput("sb_sum", 32'(o_sum), 32'(e.sum));
                checkOutput("sb_ovr", 32'(o_ovr), 32'(e.ovr));
                checkOutput("sb_count", 32'(o_count), 32'(e.count));
            end
        end
    end

    task automatic waitResult();
        int guard = 0;
        while (!(o_valid && i_out_ready) && guard < 20) begin
            @(posedge clk); #1;
            guard++;
        end
        checkOutput("result_seen", 32'(o_valid), 32'd1);
        @(posedge clk); #1;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst = 1'b1; i_prod = '0; i_prod_ovr = 1'b0; i_valid = 1'b0; i_last = 1'b0; i_out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset_sum", 32'(o_sum), 32'd0);
        checkOutput("reset_valid", 32'(o_valid), 32'd0);
        checkOutput("reset_count", 32'(o_count), 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;
        checkOutput("idle_ready", 32'(o_ready), 32'd1);

        // Four terms of 1.0 with latency check
        for (int i = 0; i < 4; i++) applyStimulus(16'h0100, 1'b0, i == 3);
        checkOutput("lat_edge1_valid", 32'(o_valid), 32'd0);
        checkOutput("lat_edge1_ready", 32'(o_ready), 32'd0);
        @(posedge clk); #1;
        checkOutput("lat_edge2_valid", 32'(o_valid), 32'd1);
        checkOutput("lat_sum", 32'(o_sum), 32'h0400);
        @(posedge clk); #1;
        checkOutput("valid_one_cycle", 32'(o_valid), 32'd0);

        // Positive and negative saturation
        applyStimulus(16'h7000, 1'b0, 1'b0);
        applyStimulus(16'h2000, 1'b0, 1'b1);
        waitResult();
        applyStimulus(16'h9000, 1'b0, 1'b0);
        applyStimulus(16'hE000, 1'b0, 1'b1);
        waitResult();

        // Mixed signs, then a 1-term frame that must not inherit anything
        applyStimulus(16'hFF00, 1'b0, 1'b0);
        applyStimulus(16'h0080, 1'b0, 1'b1);
        waitResult();
        applyStimulus(16'h0001, 1'b0, 1'b1);
        waitResult();

        // Backpressure with an input term held while the result is pending
        i_out_ready = 1'b0;
        applyStimulus(16'h0100, 1'b0, 1'b0);
        applyStimulus(16'h0100, 1'b0, 1'b1);
        i_prod = 16'h0100; i_prod_ovr = 1'b0; i_last = 1'b0; i_valid = 1'b1;
        @(posedge clk); #1;
        for (int i = 0; i < 3; i++) begin
            checkOutput("bp_valid", 32'(o_valid), 32'd1);
            checkOutput("bp_sum", 32'(o_sum), 32'h0200);
            checkOutput("bp_count", 32'(o_count), 32'd2);
            checkOutput("bp_ready", 32'(o_ready), 32'd0);
            @(posedge clk); #1;
        end
        i_out_ready = 1'b1;
        applyStimulus(16'h0100, 1'b0, 1'b0);
        applyStimulus(16'h0100, 1'b0, 1'b1);
        waitResult();

        // Upstream overflow flag on a middle term
        applyStimulus(16'h0010, 1'b0, 1'b0);
        applyStimulus(16'h0010, 1'b1, 1'b0);
        applyStimulus(16'h0010, 1'b0, 1'b1);
        waitResult();

        // Counter saturation: 260 zero terms
        for (int i = 0; i < 260; i++) applyStimulus(16'h0000, 1'b0, i == 259);
        waitResult();

        // Reset mid-frame discards the partial sum
        applyStimulus(16'h0300, 1'b0, 1'b0);
        applyStimulus(16'h0300, 1'b0, 1'b0);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        modelFirst = 1'b1;
        checkOutput("rst_sum", 32'(o_sum), 32'd0);
        checkOutput("rst_valid", 32'(o_valid), 32'd0);
        checkOutput("rst_count", 32'(o_count), 32'd0);
        checkOutput("rst_ovr", 32'(o_ovr), 32'd0);
        checkOutput("rst_ready", 32'(o_ready), 32'd1);
        applyStimulus(16'h0200, 1'b0, 1'b1);
        waitResult();

        checkOutput("sb_drained", 32'(expQueue.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", numCompared, numMismatched);
        $finish;
    end

endmodule
